// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if
//   Bundles the fetch stage's control inputs, the instruction-memory port and
//   the IF/ID pipeline-register outputs.
//   master : the fetch stage itself
//   slave  : hazard/control unit, instruction memory and decode stage
//   Signals:
//     stall, npc_sel[1:0], branch_taken, jr_target[31:0]  control from D/hazard
//     im_addr[31:0], im_instr[31:0]                       instruction-memory port
//     f_pc[31:0]                                          current fetch PC
//     d_instr, d_pc, d_pc8 [31:0], d_valid, fetch_exc     IF/ID register
interface if_fetch_stage_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] f_pc;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic        fetch_exc;

    modport master (
        input  stall, npc_sel, branch_taken, jr_target, im_instr,
        output im_addr, f_pc, d_instr, d_pc, d_pc8, d_valid, fetch_exc
    );

    modport slave (
        output stall, npc_sel, branch_taken, jr_target, im_instr,
        input  im_addr, f_pc, d_instr, d_pc, d_pc8, d_valid, fetch_exc
    );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the PC, drives
//   the word index into a combinational instruction memory and latches the
//   fetched word into the IF/ID register. Redirects (branch / j / jr) come
//   from D and use the architectural delay slot: nothing is squashed.
//   Ports:
//     clk    pipeline clock, rising edge
//     reset  asynchronous, active-high
//     bus    if_fetch_stage_if.master (control in, IM port, IF/ID outputs)
//   Optional feature:
//     FETCH_ADDR_CHECK_EN  when defined, a misaligned or out-of-text-segment
//                          fetch PC raises fetch_exc in IF/ID and replaces the
//                          instruction with a nop.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET      = 32'h0000_3000,
    parameter int          IM_DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    if_fetch_stage_if.master        bus
);

    logic [31:0]              pc_r;
    logic [31:0]              d_instr_r;
    logic [31:0]              d_pc_r;
    logic [31:0]              d_pc8_r;
    logic                     d_valid_r;

    logic [31:0]              next_pc_s;
    logic [31:0]              seq_pc_s;
    logic [31:0]              d_pc4_s;
    logic [31:0]              br_off_s;
    logic [31:0]              fetch_instr_s;
    logic [IM_DEPTH_LOG2-1:0] word_idx_s;

    // PC_RESET is word aligned, so (pc - base) >> 2 equals the difference of
    // the word-address fields; only the low IM_DEPTH_LOG2 bits are kept.
    assign word_idx_s  = pc_r[IM_DEPTH_LOG2+1:2] - PC_RESET[IM_DEPTH_LOG2+1:2];
    assign bus.im_addr = {{(32-IM_DEPTH_LOG2){1'b0}}, word_idx_s};
    assign bus.f_pc    = pc_r;

    assign seq_pc_s = pc_r + 32'd4;
    assign d_pc4_s  = d_pc_r + 32'd4;
    assign br_off_s = {{14{d_instr_r[15]}}, d_instr_r[15:0], 2'b00};

    // Next-PC select; redirects only act when D holds a real instruction.
    always_comb begin
        next_pc_s = seq_pc_s;
        if (d_valid_r) begin
            case (bus.npc_sel)
                2'b01: begin
                    if (bus.branch_taken) begin
                        next_pc_s = d_pc4_s + br_off_s;
                    end else begin
                        next_pc_s = seq_pc_s;
                    end
                end
                2'b10:   next_pc_s = {d_pc4_s[31:28], d_instr_r[25:0], 2'b00};
                2'b11:   next_pc_s = bus.jr_target;
                default: next_pc_s = seq_pc_s;
            endcase
        end else begin
            next_pc_s = seq_pc_s;
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [32:0] PC_LAST = {1'b0, PC_RESET}
                                    + (33'd1 << (IM_DEPTH_LOG2 + 2)) - 33'd4;

    logic fetch_fault_s;
    logic fetch_exc_r;

    // Misaligned or outside [PC_RESET, last text word]; 33-bit compare so a
    // segment ending at the top of memory cannot wrap.
    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00)
            || ({1'b0, addr} < {1'b0, PC_RESET})
            || ({1'b0, addr} > PC_LAST);
    endfunction

    assign fetch_fault_s = addr_fault(pc_r);
    assign fetch_instr_s = fetch_fault_s ? 32'h0000_0000 : bus.im_instr;
    assign bus.fetch_exc = fetch_exc_r;

    // Fault flag travels with the instruction through IF/ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_exc_r <= 1'b0;
        end else if (!bus.stall) begin
            fetch_exc_r <= fetch_fault_s;
        end else begin
            fetch_exc_r <= fetch_exc_r;
        end
    end
`else
    assign fetch_instr_s = bus.im_instr;
    assign bus.fetch_exc = 1'b0;
`endif

    // PC and IF/ID register; a stall freezes both so a pending redirect is
    // taken on the first unstalled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r      <= PC_RESET;
            d_instr_r <= 32'h0000_0000;
            d_pc_r    <= 32'h0000_0000;
            d_pc8_r   <= 32'h0000_0000;
            d_valid_r <= 1'b0;
        end else if (!bus.stall) begin
            pc_r      <= next_pc_s;
            d_instr_r <= fetch_instr_s;
            d_pc_r    <= pc_r;
            d_pc8_r   <= pc_r + 32'd8;
            d_valid_r <= 1'b1;
        end else begin
            pc_r      <= pc_r;
            d_instr_r <= d_instr_r;
            d_pc_r    <= d_pc_r;
            d_pc8_r   <= d_pc8_r;
            d_valid_r <= d_valid_r;
        end
    end

    assign bus.d_instr = d_instr_r;
    assign bus.d_pc    = d_pc_r;
    assign bus.d_pc8   = d_pc8_r;
    assign bus.d_valid = d_valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed scenarios (sequential flow, branch taken/not taken with delay
//   slot, j under stall, jr, fetch-address faults, async reset mid-stall)
//   followed by randomized control traffic, all compared cycle by cycle with
//   a behavioural model of the fetch stage.
module tb_if_fetch_stage;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    if_fetch_stage_if bus();

    if_fetch_stage #(
        .PC_RESET      (BASE),
        .IM_DEPTH_LOG2 (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [31:0] mem [1024];
    assign bus.im_instr = mem[bus.im_addr[9:0]];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc, m_dinstr, m_dpc, m_dpc8;
    logic        m_dvalid, m_exc;

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic EXC_ON = 1'b1;
`else
    localparam logic EXC_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic model_fault(input logic [31:0] a);
        if (!EXC_ON) return 1'b0;
        return (a % 32'd4 != 32'd0) || (a < BASE) || (a > BASE + 32'd4092);
    endfunction

    function automatic logic [31:0] model_npc();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (!m_dvalid) return seq;
        case (bus.npc_sel)
            2'd1:    return bus.branch_taken
                          ? m_dpc + 32'd4 + 32'(int'($signed(m_dinstr[15:0])) * 4)
                          : seq;
            2'd2:    return ((m_dpc + 32'd4) & 32'hF000_0000)
                          | (32'(m_dinstr[25:0]) * 32'd4);
            2'd3:    return bus.jr_target;
            default: return seq;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_dinstr = 32'd0; m_dpc = 32'd0; m_dpc8 = 32'd0;
        m_dvalid = 1'b0; m_exc = 1'b0;
    endtask

    task automatic check_all();
        chk("f_pc",      bus.f_pc, m_pc);
        chk("im_addr",   bus.im_addr, ((m_pc - BASE) / 32'd4) % 32'd1024);
        chk("d_instr",   bus.d_instr, m_dinstr);
        chk("d_pc",      bus.d_pc, m_dpc);
        chk("d_pc8",     bus.d_pc8, m_dpc8);
        chk("d_valid",   {31'd0, bus.d_valid}, {31'd0, m_dvalid});
        chk("fetch_exc", {31'd0, bus.fetch_exc}, {31'd0, m_exc});
    endtask

    task automatic set_in(input logic st, input logic [1:0] sel, input logic tk, input logic [31:0] jr);
        bus.stall = st; bus.npc_sel = sel; bus.branch_taken = tk; bus.jr_target = jr;
    endtask

    // One clock: advance the model from pre-edge inputs, then compare.
    task automatic step();
        logic [31:0] npc, word;
        logic        f;
        if (!bus.stall) begin
            npc  = model_npc();
            f    = model_fault(m_pc);
            word = mem[((m_pc - BASE) / 32'd4) % 32'd1024];
            m_dinstr = f ? 32'd0 : word;
            m_dpc    = m_pc;
            m_dpc8   = m_pc + 32'd8;
            m_dvalid = 1'b1;
            m_exc    = f;
            m_pc     = npc;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[4] = 32'h1000_FFFE;   // beq, imm16 = -2
        mem[8] = 32'h0800_0C10;   // j, index26 = 0xC10

        set_in(1'b0, 2'd0, 1'b0, 32'd0);
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        chk("rst_im_addr", bus.im_addr, 32'd0);
        reset = 1'b0;

        // Sequential flow up to the beq at 0x3010
        repeat (5) step();
        chk("seq_dpc",   bus.d_pc, 32'h0000_3010);
        chk("seq_dpc8",  bus.d_pc8, 32'h0000_3018);
        chk("seq_instr", bus.d_instr, 32'h1000_FFFE);

        // Branch not taken
        set_in(1'b0, 2'd1, 1'b0, 32'd0);
        step();
        chk("br_nt_pc", bus.f_pc, 32'h0000_3018);

        // Branch taken: delay slot 0x3014 enters D, then fetch 0x300C
        set_in(1'b0, 2'd0, 1'b0, 32'd0);
        do_reset();
        repeat (5) step();
        set_in(1'b0, 2'd1, 1'b1, 32'd0);
        step();
        chk("br_t_pc",   bus.f_pc, 32'h0000_300C);
        chk("br_slot",   bus.d_pc, 32'h0000_3014);

        // j at 0x3020 held by a 3-cycle stall
        set_in(1'b0, 2'd0, 1'b0, 32'd0);
        do_reset();
        repeat (9) step();
        chk("j_dpc", bus.d_pc, 32'h0000_3020);
        set_in(1'b1, 2'd2, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc",  bus.f_pc, 32'h0000_3024);
            chk("stall_dpc", bus.d_pc, 32'h0000_3020);
        end
        set_in(1'b0, 2'd2, 1'b0, 32'd0);
        step();
        chk("j_pc", bus.f_pc, 32'h0000_3040);

        // jr
        set_in(1'b0, 2'd3, 1'b0, 32'h0000_307C);
        step();
        chk("jr_pc",   bus.f_pc, 32'h0000_307C);
        chk("jr_addr", bus.im_addr, 32'h0000_001F);

        // Fetch-address faults: misaligned, then past the text segment
        set_in(1'b0, 2'd3, 1'b0, 32'h0000_3002);
        step();
        set_in(1'b0, 2'd0, 1'b0, 32'd0);
        step();
        chk("exc_mis", {31'd0, bus.fetch_exc}, {31'd0, EXC_ON});
        if (EXC_ON) chk("exc_mis_nop", bus.d_instr, 32'd0);
        set_in(1'b0, 2'd3, 1'b0, 32'h0000_4000);
        step();
        set_in(1'b0, 2'd0, 1'b0, 32'd0);
        step();
        chk("exc_oor", {31'd0, bus.fetch_exc}, {31'd0, EXC_ON});

        // Async reset asserted between edges during a stall
        set_in(1'b1, 2'd2, 1'b0, 32'd0);
        step();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("async_pc",    bus.f_pc, BASE);
        #1;
        reset = 1'b0;

        // Randomized control traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] jr;
            jr = ($urandom_range(0, 7) == 0) ? $urandom
                                             : BASE + 32'd4 * 32'($urandom_range(0, 1023));
            set_in(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), jr);
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives the word index into the instruction memory, and latches the fetched word into the IF/ID pipeline register.
- Computes the next PC from sequential flow or from a branch/jump redirect decided in D. Architectural delay slot: no squash on redirect.
- Sits between the hazard/control unit (stall, npc_sel) and the combinational instruction memory (word-indexed, 1024 entries).

Parameters:
- PC_RESET, 32'h0000_3000, reset PC and text-segment base
- IM_DEPTH_LOG2, 10, instruction-memory index width (1024 words)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC and IF/ID contents
- npc_sel  in  2  00 PC+4, 01 branch, 10 jump-imm (j/jal), 11 jump-reg (jr/jalr)
- branch_taken  in  1  branch compare result from D; only meaningful with npc_sel=01
- jr_target  in  32  forwarded rs value for jump-reg
- im_addr  out  32  word index into IM: (pc - PC_RESET) >> 2, low IM_DEPTH_LOG2 bits, zero-extended
- im_instr  in  32  instruction word returned combinationally by IM
- f_pc  out  32  current fetch PC
- d_instr  out  32  IF/ID instruction
- d_pc  out  32  IF/ID PC
- d_pc8  out  32  d_pc + 8, link value for jal/jalr
- d_valid  out  1  IF/ID holds a real fetched instruction
- fetch_exc  out  1  fetch-address fault (see Optional Feature)

Behaviour:
- Reset (async, any time incl. mid-stall): pc=PC_RESET; d_instr=0 (nop); d_pc=0; d_pc8=0; d_valid=0; fetch_exc=0. im_addr then reads 0.
- im_addr and f_pc are combinational from pc. IM read is same-cycle, so fetch latency is 1 cycle: the word at pc appears on d_instr after the next rising edge.
- Offsets are taken from d_instr: imm16=d_instr[15:0], index26=d_instr[25:0].
- Next PC (all arithmetic mod 2^32, wrap-around allowed):
  - default: pc+4
  - npc_sel=01 and branch_taken=1: d_pc + 4 + (sign_ext(imm16) << 2)
  - npc_sel=01 and branch_taken=0: pc+4
  - npc_sel=10: {d_pc+4 [31:28], index26, 2'b00}
  - npc_sel=11: jr_target, used verbatim (no realignment)
- Redirects are honoured only when d_valid=1; otherwise pc+4.
- Edge update when stall=0: pc<=next PC; d_instr<=im_instr; d_pc<=pc; d_pc8<=pc+8; d_valid<=1.
- stall=1: pc and all IF/ID outputs hold. Stall has priority over redirect: the instruction causing the redirect stays in D, so the redirect is taken on the first unstalled edge.
- Delay slot: the instruction at branch_pc+4 is already in IF when the redirect is applied, enters D normally, and is never squashed.
- No internal FSM beyond the pc/IF-ID registers. d_valid goes 0→1 on the first unstalled edge after reset and stays 1 until the next reset.

Optional Feature:
- Macro FETCH_ADDR_CHECK_EN.
- Defined: fetch_exc is registered into IF/ID with the instruction. It is 1 when the fetched pc has pc[1:0]!=0 or lies outside [PC_RESET, PC_RESET + 4*2^IM_DEPTH_LOG2 - 4]. In that case d_instr is forced to 0 (nop). The value holds under stall and clears on reset.
- Not defined: fetch_exc is tied to 0, im_instr is latched unchanged, and no range logic is synthesized.

Test Plan:
- Reset release, stall=0, npc_sel=00: im_addr = 0,1,2,…; d_pc = 0x3000,0x3004 on successive edges; d_pc8 = d_pc+8; d_valid rises after the 1st edge.
- Branch: d_instr=beq with imm16=0xFFFE at d_pc=0x3010, npc_sel=01, branch_taken=1 → next fetch 0x300C after the delay-slot fetch at 0x3014 completes; with branch_taken=0 → 0x3018.
- Jump: d_instr=j index26=0x0000C10 at d_pc=0x3020 → pc=0x00003040; jr with jr_target=0x0000307C → pc=0x307C, im_addr=0x1F.
- Stall for 3 cycles while npc_sel=10 is asserted: pc, d_instr, d_pc unchanged for all 3 edges; jump taken on the first edge with stall=0.
- Async reset asserted mid-stall between edges: outputs go to reset values immediately, with no clock edge required.
- Macro defined, jr_target=0x00003002 and then 0x00004000: fetch_exc=1 and d_instr=0 on the following edge. Same stimulus with macro undefined: fetch_exc=0.
